// File: rtl/mem_device_if.sv
// AXI3 channel bundles used by mem_device: one for the read direction (AR/R)
// and one for the write direction (AW/W/B).
//
// Handshake rule for every channel below: a transfer happens on the rising
// clock edge where both VALID and READY are 1; once VALID is raised the
// sender holds the payload stable until that edge, and VALID never waits
// on READY.

interface axi3_rd_bus #(
    parameter int ID_WIDTH       = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
);
    logic [ID_WIDTH-1:0]       arid;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [3:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;

    logic [ID_WIDTH-1:0]       rid;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

interface axi3_wr_bus #(
    parameter int ID_WIDTH       = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int DATA_WIDTH     = 32
);
    logic [ID_WIDTH-1:0]       awid;
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [3:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;

    logic [ID_WIDTH-1:0]       wid;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [ID_WIDTH-1:0]       bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/mem_device.sv
// AXI3 memory slave: word-organised RAM with independent read and write
// state machines, one outstanding transaction per direction.

// Word RAM with per-byte write enables and an asynchronous read port, so a
// read in the same cycle as a write to the same word sees the old contents.
module mem_ram #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic [ADDR_WIDTH-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [ADDR_WIDTH-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Byte-masked write; contents are deliberately not touched by reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_i[b]) begin
                    mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem[raddr_i];
endmodule

module mem_device #(
    parameter int BUS_WIDTH  = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    axi3_rd_bus.slave      axi3_rd_if,
    axi3_wr_bus.slave      axi3_wr_if
);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    typedef enum logic [0:0] {R_IDLE, R_BURST} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    // Word index of the beat after cur. WRAP uses len as the in-block mask,
    // which is exact for the legal wrap lengths 2/4/8/16 beats.
    function automatic logic [ADDR_WIDTH-1:0] next_word(
        input logic [ADDR_WIDTH-1:0] cur,
        input logic [3:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] inc;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] res;
        inc  = cur + 1'b1;
        mask = ADDR_WIDTH'(len);
        if (burst == BURST_FIXED) begin
            res = cur;
        end else if (burst == BURST_WRAP) begin
            res = (cur & ~mask) | (inc & mask);
        end else begin
            res = inc;
        end
        return res;
    endfunction

    // ---------------- read side ----------------
    r_state_e              r_state_q, r_state_d;
    logic [BUS_WIDTH-1:0]  r_id_q,    r_id_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,  r_addr_d;
    logic [3:0]            r_len_q,   r_len_d;
    logic [1:0]            r_burst_q, r_burst_d;
    logic [3:0]            r_beat_q,  r_beat_d;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Read state register; reset drops any burst in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_burst_q <= '0;
            r_beat_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
        end
    end

    // Read next-state: latch AR in idle, step one beat per R handshake.
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
        case (r_state_q)
            R_IDLE: begin
                if (axi3_rd_if.arvalid) begin
                    r_id_d    = axi3_rd_if.arid;
                    r_addr_d  = axi3_rd_if.araddr[ADDR_WIDTH+1:2];
                    r_len_d   = axi3_rd_if.arlen;
                    r_burst_d = axi3_rd_if.arburst;
                    r_beat_d  = '0;
                    r_state_d = R_BURST;
                end
            end
            R_BURST: begin
                if (axi3_rd_if.rready) begin
                    if (r_beat_q == r_len_q) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = next_word(r_addr_q, r_len_q, r_burst_q);
                        r_beat_d = r_beat_q + 4'd1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read outputs are decoded from state; data is zeroed outside a burst.
    assign axi3_rd_if.arready = (r_state_q == R_IDLE);
    assign axi3_rd_if.rvalid  = (r_state_q == R_BURST);
    assign axi3_rd_if.rlast   = (r_state_q == R_BURST) && (r_beat_q == r_len_q);
    assign axi3_rd_if.rid     = (r_state_q == R_BURST) ? r_id_q : '0;
    assign axi3_rd_if.rresp   = RESP_OKAY;
    assign axi3_rd_if.rdata   = (r_state_q == R_BURST) ? ram_rdata : '0;

    // ---------------- write side ----------------
    w_state_e              w_state_q, w_state_d;
    logic [BUS_WIDTH-1:0]  w_id_q,    w_id_d;
    logic [ADDR_WIDTH-1:0] w_addr_q,  w_addr_d;
    logic [3:0]            w_len_q,   w_len_d;
    logic [1:0]            w_burst_q, w_burst_d;
    logic [3:0]            w_beat_q,  w_beat_d;
    logic                  ram_we;

    // Write state register; reset abandons the burst with no B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_burst_q <= '0;
            w_beat_q  <= '0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
        end
    end

    // Write next-state: latch AW, count W beats by AWLEN, then respond.
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;
        ram_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (axi3_wr_if.awvalid) begin
                    w_id_d    = axi3_wr_if.awid;
                    w_addr_d  = axi3_wr_if.awaddr[ADDR_WIDTH+1:2];
                    w_len_d   = axi3_wr_if.awlen;
                    w_burst_d = axi3_wr_if.awburst;
                    w_beat_d  = '0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (axi3_wr_if.wvalid) begin
                    ram_we = 1'b1;
                    if (w_beat_q == w_len_q) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_addr_d = next_word(w_addr_q, w_len_q, w_burst_q);
                        w_beat_d = w_beat_q + 4'd1;
                    end
                end
            end
            W_RESP: begin
                if (axi3_wr_if.bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write outputs are decoded from state only.
    assign axi3_wr_if.awready = (w_state_q == W_IDLE);
    assign axi3_wr_if.wready  = (w_state_q == W_DATA);
    assign axi3_wr_if.bvalid  = (w_state_q == W_RESP);
    assign axi3_wr_if.bid     = (w_state_q == W_RESP) ? w_id_q : '0;
    assign axi3_wr_if.bresp   = RESP_OKAY;

    // Beat size, WID, WLAST and the address bits outside the word index
    // play no part in this device.
    logic unused_inputs;
    assign unused_inputs = ^{axi3_rd_if.arsize, axi3_rd_if.araddr,
                             axi3_wr_if.awsize, axi3_wr_if.awaddr,
                             axi3_wr_if.wid, axi3_wr_if.wlast};

    mem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .wstrb_i (axi3_wr_if.wstrb),
        .waddr_i (w_addr_q),
        .wdata_i (axi3_wr_if.wdata),
        .raddr_i (r_addr_q),
        .rdata_o (ram_rdata)
    );
endmodule

// File: tb/tb_mem_device.sv
// Directed bench for mem_device: bursts of each type, stalls, byte strobes,
// address aliasing and reset during a read burst.
module tb_mem_device;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] exp_q[$];
    logic [31:0] wq[$];

    axi3_rd_bus #(.ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .DATA_WIDTH(32)) rd_bus ();
    axi3_wr_bus #(.ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .DATA_WIDTH(32)) wr_bus ();

    mem_device #(.BUS_WIDTH(4), .ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .axi3_rd_if (rd_bus),
        .axi3_wr_if (wr_bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read burst; expected beats are taken from exp_q in order.
    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst,
                            input bit stall);
        int cyc;
        @(posedge clk); #1;
        rd_bus.arid    = id;
        rd_bus.araddr  = addr;
        rd_bus.arlen   = len;
        rd_bus.arsize  = 3'd2;
        rd_bus.arburst = burst;
        rd_bus.arvalid = 1'b1;
        rd_bus.rready  = !stall;
        @(negedge clk);
        chk("arready_idle", 32'(rd_bus.arready), 32'd1);
        @(posedge clk); #1;
        rd_bus.arvalid = 1'b0;
        @(negedge clk);
        chk("first_beat_latency", 32'(rd_bus.rvalid), 32'd1);
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            chk("rvalid", 32'(rd_bus.rvalid), 32'd1);
            chk("rdata", rd_bus.rdata, exp_q[0]);
            chk("rid", 32'(rd_bus.rid), 32'(id));
            chk("rlast", 32'(rd_bus.rlast), 32'(exp_q.size() == 1));
            if (rd_bus.rready) void'(exp_q.pop_front());
            @(posedge clk); #1;
            if (stall) rd_bus.rready = !rd_bus.rready;
            cyc++;
            @(negedge clk);
        end
        chk("read_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        chk("rvalid_after_last", 32'(rd_bus.rvalid), 32'd0);
        chk("arready_after_last", 32'(rd_bus.arready), 32'd1);
        rd_bus.rready = 1'b0;
    endtask

    // Write burst; data beats come from wq, then exactly one B response.
    task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input logic [1:0] burst,
                            input logic [3:0] strb);
        int nb;
        @(posedge clk); #1;
        wr_bus.awid    = id;
        wr_bus.awaddr  = addr;
        wr_bus.awlen   = len;
        wr_bus.awsize  = 3'd2;
        wr_bus.awburst = burst;
        wr_bus.awvalid = 1'b1;
        @(negedge clk);
        chk("awready_idle", 32'(wr_bus.awready), 32'd1);
        @(posedge clk); #1;
        wr_bus.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wr_bus.wvalid = 1'b1;
            wr_bus.wdata  = wq.pop_front();
            wr_bus.wstrb  = strb;
            wr_bus.wlast  = (i == int'(len));
            @(negedge clk);
            chk("wready", 32'(wr_bus.wready), 32'd1);
            @(posedge clk); #1;
        end
        wr_bus.wvalid = 1'b0;
        wr_bus.wlast  = 1'b0;
        wr_bus.bready = 1'b1;
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wr_bus.bvalid) begin
                nb++;
                chk("bid", 32'(wr_bus.bid), 32'(id));
                chk("bresp", 32'(wr_bus.bresp), 32'd0);
            end
            @(posedge clk); #1;
        end
        chk("bvalid_count", 32'(nb), 32'd1);
        wr_bus.bready = 1'b0;
        @(negedge clk);
        chk("awready_after_b", 32'(wr_bus.awready), 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rd_bus.arid = '0; rd_bus.araddr = '0; rd_bus.arlen = '0; rd_bus.arsize = '0;
        rd_bus.arburst = '0; rd_bus.arvalid = 1'b0; rd_bus.rready = 1'b0;
        wr_bus.awid = '0; wr_bus.awaddr = '0; wr_bus.awlen = '0; wr_bus.awsize = '0;
        wr_bus.awburst = '0; wr_bus.awvalid = 1'b0; wr_bus.wid = '0; wr_bus.wdata = '0;
        wr_bus.wstrb = '0; wr_bus.wlast = 1'b0; wr_bus.wvalid = 1'b0; wr_bus.bready = 1'b0;
        for (int i = 0; i < 16; i++) dut.ram.mem[i] = 32'h1000 + i;
        dut.ram.mem[32] = 32'hFFFF_FFFF;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rvalid", 32'(rd_bus.rvalid), 32'd0);
        chk("rst_rlast", 32'(rd_bus.rlast), 32'd0);
        chk("rst_rid", 32'(rd_bus.rid), 32'd0);
        chk("rst_rdata", rd_bus.rdata, 32'd0);
        chk("rst_wready", 32'(wr_bus.wready), 32'd0);
        chk("rst_bvalid", 32'(wr_bus.bvalid), 32'd0);
        chk("rst_bid", 32'(wr_bus.bid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_arready", 32'(rd_bus.arready), 32'd1);
        chk("rst_awready", 32'(wr_bus.awready), 32'd1);

        // INCR read of 8 words from 0x0 at full rate
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h1000 + i);
        rd_burst(4'h5, 32'h0, 4'd7, 2'b01, 1'b0);

        // INCR read from 0x20 with RREADY toggling
        for (int i = 8; i < 16; i++) exp_q.push_back(32'h1000 + i);
        rd_burst(4'h3, 32'h20, 4'd7, 2'b01, 1'b1);

        // INCR write of 4 words at 0x40, then read back
        for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + i);
        wr_burst(4'h9, 32'h40, 4'd3, 2'b01, 4'hF);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'hA0 + i);
        rd_burst(4'h2, 32'h40, 4'd3, 2'b01, 1'b0);

        // byte strobes 0x5 over an all-ones word
        wq.push_back(32'h1122_3344);
        wr_burst(4'hC, 32'h80, 4'd0, 2'b01, 4'h5);
        exp_q.push_back(32'hFF22_FF44);
        rd_burst(4'h7, 32'h80, 4'd0, 2'b01, 1'b0);

        // WRAP of 4 beats starting at word 2
        exp_q.push_back(32'h1002); exp_q.push_back(32'h1003);
        exp_q.push_back(32'h1000); exp_q.push_back(32'h1001);
        rd_burst(4'hA, 32'h08, 4'd3, 2'b10, 1'b0);

        // FIXED burst repeats word 5
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h1005);
        rd_burst(4'h1, 32'h14, 4'd2, 2'b00, 1'b0);

        // upper address bits alias onto word 3
        exp_q.push_back(32'h1003);
        rd_burst(4'hF, 32'h0004_000C, 4'd0, 2'b01, 1'b0);

        // reset during beat 3 of an 8-beat read
        @(posedge clk); #1;
        rd_bus.arid = 4'h6; rd_bus.araddr = 32'h0; rd_bus.arlen = 4'd7;
        rd_bus.arburst = 2'b01; rd_bus.arvalid = 1'b1; rd_bus.rready = 1'b1;
        @(posedge clk); #1;
        rd_bus.arvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("pre_rst_beat", rd_bus.rdata, 32'h1000 + k);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("pre_rst_beat3", rd_bus.rdata, 32'h1003);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rvalid", 32'(rd_bus.rvalid), 32'd0);
        chk("abort_rdata", rd_bus.rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_bus.rready = 1'b0;
        @(negedge clk);
        chk("abort_arready", 32'(rd_bus.arready), 32'd1);
        exp_q.push_back(32'h1000);
        rd_burst(4'h4, 32'h0, 4'd0, 2'b01, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_device.md
MEM_DEVICE -- requirements
Module: mem_device

Interface
REQ-001 Parameter BUS_WIDTH, default 4: width of all AXI ID fields (ARID, RID, AWID, WID, BID).
REQ-002 Parameter ADDR_WIDTH, default 16: word-address width; memory depth 2^ADDR_WIDTH words.
REQ-003 Parameter DATA_WIDTH, default 32: AXI data width and word width; WSTRB width DATA_WIDTH/8.
REQ-004 Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
REQ-005 Port list:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- axi3_rd_if  slave modport  AR/R channel bundle, ID width BUS_WIDTH
- axi3_wr_if  slave modport  AW/W/B channel bundle, ID width BUS_WIDTH
REQ-006 Storage SHALL be an internal instance named ram holding an array mem[0 : 2^ADDR_WIDTH-1] of DATA_WIDTH bits, so benches can preload it hierarchically (mem_device.ram.mem[i]).

Function
REQ-007 Byte address A SHALL map to word A[ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing); word index wraps modulo 2^ADDR_WIDTH.
REQ-008 Only 4-byte beats are supported; ARSIZE/AWSIZE are ignored and every beat advances the address by one word.
REQ-009 Bursts: ARLEN/AWLEN+1 beats (1..16); FIXED keeps the address; INCR increments; WRAP wraps within the aligned (len+1)-word block.
REQ-010 Read FSM states: R_IDLE, R_BURST.
- R_IDLE: ARREADY=1, RVALID=0.
- On ARVALID&ARREADY, latch ID, address, length and burst type; go to R_BURST.
REQ-011 In R_BURST: RVALID=1, RID=latched ID, RRESP=OKAY, RDATA=mem[current word].
- RLAST=1 exactly on beat index == ARLEN.
- Advance on RVALID&RREADY; return to R_IDLE after the last beat handshakes.
REQ-012 Read latency: first beat valid in the cycle after the AR handshake; one beat per cycle while RREADY=1; the current beat is held stable while RREADY=0.
REQ-013 Write FSM states: W_IDLE, W_DATA, W_RESP.
- W_IDLE: AWREADY=1; the AW handshake latches ID, address, length and burst type, then goes to W_DATA.
- W_DATA: WREADY=1; each WVALID&WREADY writes the enabled bytes (per WSTRB bit) of WDATA to mem[current word].
- W_DATA: after beat index == AWLEN, goes to W_RESP; WLAST and WID are ignored.
- W_RESP: BVALID=1, BID=latched ID, BRESP=OKAY; returns to W_IDLE on BREADY.
REQ-014 Read and write FSMs SHALL be independent and concurrent, with one outstanding transaction per direction; ARREADY/AWREADY are 0 outside their IDLE state.
REQ-015 Same-cycle write and read of one word: the read beat presented in that cycle SHALL show the pre-write data; later beats show the new data.
REQ-016 All slave outputs SHALL be registered or decoded from FSM state only; no combinational path from input valid to output ready.

Reset
REQ-017 While rst=1: both FSMs go to IDLE; ARREADY=AWREADY=1 after the reset cycle; RVALID=WREADY=BVALID=RLAST=0; RID/BID/RDATA=0.
REQ-018 Reset mid-burst SHALL abort the transaction without a response; ram contents are never cleared by reset.

Verification
REQ-019 Preload mem[i]=i+0x1000 for i=0..15; AR INCR addr 0x0, ARLEN=7, RREADY=1 -> 8 beats 0x1000..0x1007 on consecutive cycles, RLAST on the 8th, RID=ARID.
REQ-020 AR INCR addr 0x20, ARLEN=7 with RREADY toggled every other cycle -> beats 0x1008..0x100F in order; no beat lost or duplicated while stalled.
REQ-021 AW INCR addr 0x40, AWLEN=3, data 0xA0..0xA3, WSTRB=0xF -> BVALID once with BID=AWID; a readback returns 0xA0..0xA3.
REQ-022 Write 0x11223344 to addr 0x80 with WSTRB=0x5 over 0xFFFFFFFF -> readback returns 0xFF22FF44.
REQ-023 Assert rst during beat 3 of an 8-beat read -> RVALID=0 the next cycle and ARREADY=1 after release; a new read of addr 0x0 returns 0x1000.
REQ-024 WRAP read ARLEN=3 at addr 0x08 -> words 2,3,0,1.
